// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and framing constants for the UART word loader
package loader_pkg;
   typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DRAIN} state_t;
   localparam logic [7:0] HDR_INST_DEF = 8'h49;
   localparam logic [7:0] HDR_DATA_DEF = 8'h44;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-gap counter that saturates and flags expiry at TIMEOUT_CYCLES
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000,
   localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [W-1:0] cnt;
   assign expired = cnt == W'(TIMEOUT_CYCLES);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clr || !en) cnt <= '0;
      else if (!expired) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: parses header/count/data byte frames into 32-bit RAM write strobes
module uart_word_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] HDR_INST = HDR_INST_DEF,
   parameter logic [7:0] HDR_DATA = HDR_DATA_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              upg_wen_o,
   output logic [ADDR_W-1:0] upg_adr_o,
   output logic [DATA_W-1:0] upg_dat_o,
   output logic              upg_tgt_o,
   output logic              upg_done_o,
   output logic              err_o
);
   localparam int MAX_WORDS = 1 << ADDR_W;
   state_t state;
   logic [1:0] k;
   logic [15:0] n, wcnt, n_new;
   logic [DATA_W-9:0] sh;
   logic expired;
   assign n_new = {rx_byte, n[7:0]};
   loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (rx_valid),
      .en      (state != IDLE),
      .expired (expired)
   );
   // Bytes are shifted in LSB-first; the word only reaches upg_dat_o when complete,
   // so the output keeps the last written word while the next one assembles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         upg_wen_o <= 1'b0;
         upg_adr_o <= '0;
         upg_dat_o <= '0;
         upg_tgt_o <= 1'b0;
         upg_done_o <= 1'b1;
         err_o <= 1'b0;
         k <= '0;
         n <= '0;
         wcnt <= '0;
         sh <= '0;
      end else begin
         upg_wen_o <= 1'b0;
         if (state != IDLE && expired) begin
            state <= IDLE;
            upg_done_o <= 1'b1;
            err_o <= 1'b1;
         end else begin
            case (state)
               IDLE: if (rx_valid && (rx_byte == HDR_INST || rx_byte == HDR_DATA)) begin
                  upg_tgt_o <= rx_byte == HDR_DATA;
                  err_o <= 1'b0;
                  upg_done_o <= 1'b0;
                  state <= CNT_LO;
               end
               CNT_LO: if (rx_valid) begin
                  n[7:0] <= rx_byte;
                  state <= CNT_HI;
               end
               CNT_HI: if (rx_valid) begin
                  n[15:8] <= rx_byte;
                  if (n_new == 16'd0) begin
                     upg_done_o <= 1'b1;
                     state <= IDLE;
                  end else if (int'(n_new) > MAX_WORDS) begin
                     err_o <= 1'b1;
                     state <= DRAIN;
                  end else begin
                     upg_adr_o <= '0;
                     k <= '0;
                     wcnt <= '0;
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (rx_valid) begin
                     k <= k + 2'd1;
                     if (k == 2'(BYTES_PER_WORD - 1)) begin
                        upg_dat_o <= {rx_byte, sh};
                        upg_wen_o <= 1'b1;
                        wcnt <= wcnt + 16'd1;
                     end else sh <= {rx_byte, sh[DATA_W-9:8]};
                  end
                  if (upg_wen_o) begin
                     if (wcnt == n) begin
                        upg_done_o <= 1'b1;
                        state <= IDLE;
                     end else upg_adr_o <= upg_adr_o + 1'b1;
                  end
               end
               DRAIN: ;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
